// File: rtl/prbs4_if.sv
// Sample/result bundle between a PRBS4 source and the prbs4_checker.
// The master side drives samples and the counter clear; the slave side
// (the checker) returns lock status and error reporting.
interface prbs4_if #(
  parameter int ERR_W = 8
);
  logic             din_valid;
  logic [3:0]       din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output din_valid,
    output din,
    output clr_cnt,
    input  locked,
    input  err_pulse,
    input  err_cnt
  );

  modport slave (
    input  din_valid,
    input  din,
    input  clr_cnt,
    output locked,
    output err_pulse,
    output err_cnt
  );
endinterface

// File: rtl/prbs4_checker.sv
// PRBS4 checker for the x^4+x^3+1 generator (period 15).
// Self-synchronises to the incoming state word, then counts every
// misprediction while locked.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SEARCH | seeding predictor from din, counting consecutive hits
// LOCKED | free-running predictor, flagging/counting mismatches
module prbs4_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic    clk,
  input  logic    rst,
  prbs4_if.slave  bus
);

  localparam int RUN_W  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MISS_W = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [3:0]         pred_q,      pred_d;
  logic               seeded_q,    seeded_d;
  logic [RUN_W-1:0]   run_q,       run_d;
  logic [MISS_W-1:0]  miss_q,      miss_d;
  logic               locked_q,    locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;

  logic               din_zero;
  logic               hit;
  logic               mis;

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  assign din_zero = (bus.din == 4'b0000);

  // Hit/miss qualifiers; 0000 is the LFSR lock-up word and never legal.
  assign hit = seeded_q & (bus.din == pred_q) & ~din_zero;
  assign mis = (bus.din != pred_q) | din_zero;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEARCH;
      pred_q      <= 4'b0000;
      seeded_q    <= 1'b0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      seeded_q    <= seeded_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and output logic; idle cycles only drop err_pulse.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    seeded_d    = seeded_q;
    run_d       = run_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bus.din_valid) begin
      unique case (state_q)
        SEARCH: begin
          // Reload from the received word; a legal word seeds the predictor.
          pred_d   = nxt(bus.din);
          seeded_d = ~din_zero;
          if (hit) begin
            run_d = run_q + 1'b1;
            if (run_q == RUN_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              run_d    = '0;
              miss_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end

        LOCKED: begin
          // Predictor free-runs so a corrupted word cannot re-seed it.
          pred_d = nxt(pred_q);
          if (mis) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            miss_d = miss_q + 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              seeded_d = 1'b0;
              run_d    = '0;
              miss_d   = '0;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear has priority over a same-cycle increment.
    if (bus.clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
